// File: rtl/data_mem.sv
// Single-port word data memory for the CPU memory stage: one request at a time,
// programmable wait states, one-cycle ready pulse and out-of-range fault.
module data_mem #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_async,
  input  logic        mem_access_active,
  input  logic        mem_write_enable,
  input  logic [19:0] mem_address,
  input  logic [31:0] mem_write_value,
  output logic [31:0] mem_read_value,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_fault
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [DEPTH];

  logic                  complete;
  logic                  c_we;
  logic                  c_in_range;
  logic [19:0]           c_addr;
  logic [31:0]           c_wdata;
  logic [DEPTH_LOG2-1:0] c_idx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = 1'b0;
    complete = 1'b0;
    // With zero wait states the request completes on its accept edge, so the
    // live inputs are the completing request; otherwise the captured copy is.
    c_addr   = mem_address;
    c_we     = mem_write_enable;
    c_wdata  = mem_write_value;

    case (state_q)
      ST_WAIT: begin
        c_addr  = addr_q;
        c_we    = we_q;
        c_wdata = wdata_q;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = ST_DONE;
          complete = 1'b1;
        end
      end
      default: begin
        if (mem_access_active) begin
          addr_d  = mem_address;
          we_d    = mem_write_enable;
          wdata_d = mem_write_value;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d  = ST_DONE;
            complete = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    c_in_range = (c_addr >> DEPTH_LOG2) == '0;
    c_idx      = c_addr[DEPTH_LOG2-1:0];

    if (complete) begin
      fault_d = ~c_in_range;
      if (!c_we) begin
        rdata_d = c_in_range ? mem_q[c_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Array is deliberately not reset; an abandoned request never reaches complete.
  always_ff @(posedge clk) begin
    if (complete && c_we && c_in_range) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  assign mem_read_value = rdata_q;
  assign mem_ready      = (state_q == ST_DONE);
  assign mem_busy       = (state_q == ST_WAIT);
  assign mem_fault      = fault_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: dut_a uses two wait states, dut_b zero wait states.
module tb_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_act, a_we, a_rdy, a_busy, a_flt;
  logic [19:0] a_addr;
  logic [31:0] a_wd, a_rd;
  logic        b_act, b_we, b_rdy, b_busy, b_flt;
  logic [19:0] b_addr;
  logic [31:0] b_wd, b_rd;

  data_mem #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst_async(rst), .mem_access_active(a_act), .mem_write_enable(a_we),
    .mem_address(a_addr), .mem_write_value(a_wd), .mem_read_value(a_rd),
    .mem_ready(a_rdy), .mem_busy(a_busy), .mem_fault(a_flt));

  data_mem #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_async(rst), .mem_access_active(b_act), .mem_write_enable(b_we),
    .mem_address(b_addr), .mem_write_value(b_wd), .mem_read_value(b_rd),
    .mem_ready(b_rdy), .mem_busy(b_busy), .mem_fault(b_flt));

  typedef struct packed {
    logic [31:0] rd;
    logic        flt;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] mdl [2][1024];
  logic [31:0] rd_m [2];
  int          errors = 0;
  int          checks = 0;

  // Reference behaviour: s=0 for dut_a, s=1 for dut_b.
  function automatic exp_t model(input int unsigned s, input logic we,
                                 input logic [19:0] addr, input logic [31:0] wd);
    exp_t e;
    logic ok;
    ok = (addr < 20'd1024);
    if (we) begin
      if (ok) mdl[s][addr[9:0]] = wd;
    end else begin
      rd_m[s] = ok ? mdl[s][addr[9:0]] : 32'h0;
    end
    e.rd  = rd_m[s];
    e.flt = ~ok;
    return e;
  endfunction

  task automatic cyc_a(input logic act, input logic we, input logic [19:0] addr,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    a_act = act; a_we = we; a_addr = addr; a_wd = wd;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic act, input logic we, input logic [19:0] addr,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    b_act = act; b_we = we; b_addr = addr; b_wd = wd;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_act = 0; a_we = 0; a_addr = '0; a_wd = '0;
    b_act = 0; b_we = 0; b_addr = '0; b_wd = '0;
    repeat (2) @(negedge clk);
    checks++; if (a_rd !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", a_rd); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", a_rdy); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_flt !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", a_flt); end
    checks++;
    if ({b_rdy, b_busy, b_flt, b_rd} !== 35'h0) begin
      errors++; $display("FAIL reset_b got=%b%b%b_%h exp=0", b_rdy, b_busy, b_flt, b_rd);
    end
    rst = 1'b0;
    rd_m[0] = '0; rd_m[1] = '0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic act, we, er;
    logic [19:0] addr;
    logic [31:0] wd;
    for (int c = 0; c < 7; c++) begin
      act = (c < 5); we = (c < 2); wd = (c == 0) ? 32'h11 : 32'h22;
      addr = (c == 1 || c == 3) ? 20'd2 : 20'd1;
      if (act) qb.push_back(model(1, we, addr, wd));
      cyc_b(act, we, addr, wd);
      er = (c >= 1 && c <= 5);
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy c=%0d got=%b exp=0", c, b_busy); end
      checks++; if (b_rdy !== er) begin errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, b_rdy, er); end
      if (b_rdy) begin
        if (qb.size() == 0) begin errors++; $display("FAIL b2b_extra_ready c=%0d got=1 exp=0", c); end
        else begin
          e = qb.pop_front();
          checks++; if (b_rd !== e.rd) begin errors++; $display("FAIL b2b_rd c=%0d got=%h exp=%h", c, b_rd, e.rd); end
          checks++; if (b_flt !== e.flt) begin errors++; $display("FAIL b2b_fault c=%0d got=%b exp=%b", c, b_flt, e.flt); end
        end
      end
    end
  endtask

  task automatic test_store_timing;
    exp_t e;
    logic eb, er;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) qa.push_back(model(0, 1'b1, 20'd5, 32'hDEADBEEF));
      cyc_a(c == 0, 1'b1, 20'd5, 32'hDEADBEEF);
      eb = (c == 1 || c == 2); er = (c == 3);
      checks++; if (a_busy !== eb) begin errors++; $display("FAIL st_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      checks++; if (a_rdy !== er) begin errors++; $display("FAIL st_ready c=%0d got=%b exp=%b", c, a_rdy, er); end
      if (a_rdy) begin
        if (qa.size() == 0) begin errors++; $display("FAIL st_extra_ready c=%0d got=1 exp=0", c); end
        else begin
          e = qa.pop_front();
          checks++; if (a_rd !== e.rd) begin errors++; $display("FAIL st_rd c=%0d got=%h exp=%h", c, a_rd, e.rd); end
          checks++; if (a_flt !== e.flt) begin errors++; $display("FAIL st_fault c=%0d got=%b exp=%b", c, a_flt, e.flt); end
        end
      end else begin
        checks++; if (a_flt !== 1'b0) begin errors++; $display("FAIL st_fault_idle c=%0d got=%b exp=0", c, a_flt); end
      end
    end
  endtask

  task automatic test_read_after_write;
    exp_t e;
    logic act, we, eb, er;
    for (int c = 0; c < 8; c++) begin
      act = (c == 0 || c == 3); we = (c == 0);
      if (act) qa.push_back(model(0, we, 20'd7, 32'h12345678));
      cyc_a(act, we, 20'd7, 32'h12345678);
      eb = (c == 1 || c == 2 || c == 4 || c == 5); er = (c == 3 || c == 6);
      checks++; if (a_busy !== eb) begin errors++; $display("FAIL raw_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      checks++; if (a_rdy !== er) begin errors++; $display("FAIL raw_ready c=%0d got=%b exp=%b", c, a_rdy, er); end
      if (a_rdy) begin
        if (qa.size() == 0) begin errors++; $display("FAIL raw_extra_ready c=%0d got=1 exp=0", c); end
        else begin
          e = qa.pop_front();
          checks++; if (a_rd !== e.rd) begin errors++; $display("FAIL raw_rd c=%0d got=%h exp=%h", c, a_rd, e.rd); end
          checks++; if (a_flt !== e.flt) begin errors++; $display("FAIL raw_fault c=%0d got=%b exp=%b", c, a_flt, e.flt); end
        end
      end
    end
  endtask

  task automatic test_wait_ignore;
    exp_t e;
    logic act, we, eb, er;
    logic [19:0] addr;
    logic [31:0] wd;
    for (int c = 0; c < 9; c++) begin
      act = (c <= 2 || c == 4); we = (c == 0);
      addr = (c == 1 || c == 2) ? 20'd5 : 20'd9;
      wd = (c == 1 || c == 2) ? 32'h00000BAD : 32'h00000099;
      if (c == 0 || c == 4) qa.push_back(model(0, we, addr, wd));
      cyc_a(act, we, addr, wd);
      eb = (c == 1 || c == 2 || c == 5 || c == 6); er = (c == 3 || c == 7);
      checks++; if (a_busy !== eb) begin errors++; $display("FAIL wi_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      checks++; if (a_rdy !== er) begin errors++; $display("FAIL wi_ready c=%0d got=%b exp=%b", c, a_rdy, er); end
      if (a_rdy) begin
        if (qa.size() == 0) begin errors++; $display("FAIL wi_extra_ready c=%0d got=1 exp=0", c); end
        else begin
          e = qa.pop_front();
          checks++; if (a_rd !== e.rd) begin errors++; $display("FAIL wi_rd c=%0d got=%h exp=%h", c, a_rd, e.rd); end
          checks++; if (a_flt !== e.flt) begin errors++; $display("FAIL wi_fault c=%0d got=%b exp=%b", c, a_flt, e.flt); end
        end
      end
    end
  endtask

  task automatic test_fault;
    exp_t e;
    logic act, we, eb, er;
    logic [19:0] addr;
    logic [31:0] wd;
    for (int c = 0; c < 16; c++) begin
      act = (c % 4 == 0);
      case (c / 4)
        0:       begin we = 1; addr = 20'h00000; wd = 32'h5A5A5A5A; end
        1:       begin we = 0; addr = 20'h00400; wd = 32'h0; end
        2:       begin we = 1; addr = 20'h00400; wd = 32'hFFFFFFFF; end
        default: begin we = 0; addr = 20'h00000; wd = 32'h0; end
      endcase
      if (act) qa.push_back(model(0, we, addr, wd));
      cyc_a(act, we, addr, wd);
      eb = (c % 4 == 1 || c % 4 == 2); er = (c % 4 == 3);
      checks++; if (a_busy !== eb) begin errors++; $display("FAIL flt_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      checks++; if (a_rdy !== er) begin errors++; $display("FAIL flt_ready c=%0d got=%b exp=%b", c, a_rdy, er); end
      if (a_rdy) begin
        if (qa.size() == 0) begin errors++; $display("FAIL flt_extra_ready c=%0d got=1 exp=0", c); end
        else begin
          e = qa.pop_front();
          checks++; if (a_rd !== e.rd) begin errors++; $display("FAIL flt_rd c=%0d got=%h exp=%h", c, a_rd, e.rd); end
          checks++; if (a_flt !== e.flt) begin errors++; $display("FAIL flt_fault c=%0d got=%b exp=%b", c, a_flt, e.flt); end
        end
      end else begin
        checks++; if (a_flt !== 1'b0) begin errors++; $display("FAIL flt_fault_idle c=%0d got=%b exp=0", c, a_flt); end
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic act, we, eb, er;
    logic [31:0] wd;
    // Store 0xAA to 3, load it back, then start a store of 0x55 that gets reset.
    for (int c = 0; c < 10; c++) begin
      act = (c == 0 || c == 4 || c == 8); we = (c != 4);
      wd = (c == 8) ? 32'h55 : 32'hAA;
      if (c == 0 || c == 4) qa.push_back(model(0, we, 20'd3, wd));
      cyc_a(act, we, 20'd3, wd);
      eb = (c == 1 || c == 2 || c == 5 || c == 6 || c == 9); er = (c == 3 || c == 7);
      checks++; if (a_busy !== eb) begin errors++; $display("FAIL rm_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      checks++; if (a_rdy !== er) begin errors++; $display("FAIL rm_ready c=%0d got=%b exp=%b", c, a_rdy, er); end
      if (a_rdy) begin
        if (qa.size() == 0) begin errors++; $display("FAIL rm_extra_ready c=%0d got=1 exp=0", c); end
        else begin
          e = qa.pop_front();
          checks++; if (a_rd !== e.rd) begin errors++; $display("FAIL rm_rd c=%0d got=%h exp=%h", c, a_rd, e.rd); end
        end
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (a_rd !== 32'h0) begin errors++; $display("FAIL rm_rst_rd got=%h exp=0", a_rd); end
    checks++; if ({a_rdy, a_busy, a_flt} !== 3'b000) begin
      errors++; $display("FAIL rm_rst_ctl got=%b%b%b exp=000", a_rdy, a_busy, a_flt);
    end
    rd_m[0] = '0; rd_m[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) qa.push_back(model(0, 1'b0, 20'd3, 32'h0));
      cyc_a(c == 0, 1'b0, 20'd3, 32'h0);
      eb = (c == 1 || c == 2); er = (c == 3);
      checks++; if (a_busy !== eb) begin errors++; $display("FAIL rm2_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      checks++; if (a_rdy !== er) begin errors++; $display("FAIL rm2_ready c=%0d got=%b exp=%b", c, a_rdy, er); end
      if (a_rdy) begin
        if (qa.size() == 0) begin errors++; $display("FAIL rm2_extra_ready c=%0d got=1 exp=0", c); end
        else begin
          e = qa.pop_front();
          checks++; if (a_rd !== e.rd) begin errors++; $display("FAIL rm2_rd c=%0d got=%h exp=%h", c, a_rd, e.rd); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store_timing();
    test_read_after_write();
    test_wait_ignore();
    test_fault();
    test_reset_mid();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL missing_ready got=%0d/%0d pending exp=0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Single-port data memory that services the load/store requests issued by the CPU's memory-access pipeline stage. It accepts one word request at a time, applies a programmable number of wait states, then completes the request with a one-cycle `mem_ready` pulse. Read data stays on `mem_read_value` until the next read completes. Out-of-range addresses raise `mem_fault`.

## Interface

- `DEPTH_LOG2`, 10: memory holds 2^DEPTH_LOG2 32-bit words; legal range 4..16.
- `WAIT_STATES`, 2: extra cycles between acceptance and completion; legal range 0..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_async` input 1: reset, asynchronous and active-high.
- `mem_access_active` input 1: a request is present this cycle.
- `mem_write_enable` input 1: the request is a store (1) or a load (0); only meaningful while `mem_access_active` is high.
- `mem_address` input 20: word address.
- `mem_write_value` input 32: store data.
- `mem_read_value` output 32: load result, registered.
- `mem_ready` output 1: one-cycle completion pulse.
- `mem_busy` output 1: high while a request is in wait states; requests presented in these cycles are ignored.
- `mem_fault` output 1: one-cycle pulse, coincident with `mem_ready`, when the completed request was out of range.

## Operation

- FSM states:
  - IDLE: no request outstanding.
  - WAIT: waiting out the wait-state count.
  - DONE: completing; lasts exactly one cycle.
- Acceptance:
  - In IDLE or DONE, `mem_access_active`=1 accepts a request.
  - On acceptance, register `mem_address`, `mem_write_enable` and `mem_write_value`.
  - On acceptance, load wait counter with `WAIT_STATES`.
- Transitions:
  - IDLE→IDLE when no request.
  - IDLE/DONE→WAIT on accept when `WAIT_STATES`>0.
  - IDLE/DONE→DONE on accept when `WAIT_STATES`=0.
  - WAIT: decrement counter each cycle; when counter reaches 1, next state is DONE.
  - DONE→IDLE when no new request.
- In WAIT, input changes are ignored; the captured request is authoritative.
- Range check:
  - Address is in range when `addr[19:DEPTH_LOG2]`=0.
  - Only `addr[DEPTH_LOG2-1:0]` indexes the array.
- Completion, on the edge entering DONE:
  - In-range store: write the captured data to the array.
  - In-range load: `mem_read_value` ← array word.
  - Out-of-range store: discard; array unchanged.
  - Out-of-range load: `mem_read_value` ← 0.
  - Any out-of-range request: assert `mem_fault`.
- `mem_read_value` changes only on load completion. Stores and faults-on-store leave it unchanged.
- `mem_ready` = (state==DONE). `mem_busy` = (state==WAIT). Both decoded from registered state, no combinational input paths.
- Array contents are not reset and are undefined after power-up.

## Timing

- Request present in cycle 0 and accepted at the end of cycle 0. `mem_ready` is high in cycle 1+`WAIT_STATES`, with `mem_read_value` valid in that same cycle.
- Throughput is one request per `WAIT_STATES`+1 cycles. A request presented during the DONE cycle is accepted, so back-to-back requests have no idle bubble.
- Read-after-write: a load accepted in or after the store's DONE cycle returns the new data.
- Reset values: state IDLE, counter 0, `mem_read_value`=0, `mem_ready`=0, `mem_busy`=0, `mem_fault`=0.
- Reset mid-operation:
  - Outstanding request is abandoned and no `mem_ready` is produced.
  - A pending store is not written.
  - Array words are left untouched.
- `mem_access_active` held high across DONE and back into IDLE means a new request is accepted each time the FSM is in IDLE or DONE. Each is a distinct request; the requester drops `mem_access_active` after `mem_ready`.

## Test plan

- Reset, then with `WAIT_STATES`=2, store 0xDEADBEEF to address 5 in cycle 0 -> `mem_busy` high in cycles 1–2, `mem_ready` high in cycle 3 only, `mem_fault`=0.
- Store 0x12345678 to address 7, then load from address 7 presented in the store's DONE cycle -> load's `mem_ready` arrives 3 cycles later with `mem_read_value`=0x12345678.
- `WAIT_STATES`=0: alternating loads of addresses 1 and 2 (preloaded 0x11, 0x22) every cycle -> `mem_ready` high every cycle, `mem_read_value` sequence 0x11, 0x22, 0x11 one cycle behind requests, `mem_busy` never high.
- `DEPTH_LOG2`=10, load from address 0x00400 -> `mem_ready` and `mem_fault` both pulse, `mem_read_value`=0. Store 0xFFFFFFFF to address 0x00400 -> fault pulse, and address 0x000 is unchanged.
- Change `mem_address` and `mem_write_value` during WAIT cycles -> completion uses the originally captured values, and the changed inputs are not accepted as a new request.
- Assert `rst_async` mid-WAIT of a store to address 3 (old value 0xAA) -> outputs 0 immediately, no `mem_ready`, and a later load of address 3 returns 0xAA.
